// File: rtl/mem_port_arb_pkg.sv
// Shared CPU memory-port definitions: arbiter state encoding, store-size codes
// and the default RAM read latency.
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } arb_state_t;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_BYTE = 2'b01;
  localparam logic [1:0] WE_HALF = 2'b10;
  localparam logic [1:0] WE_WORD = 2'b11;

  localparam int RAM_LAT_DEFAULT = 1;
  localparam int LAT_W           = 3;

endpackage

// File: rtl/mem_port_arb_if.sv
// Bundle of the fetch port, data port and single-port RAM signals around the
// memory arbiter; master is the CPU/RAM side, slave is the arbiter.
interface mem_port_arb_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_inst;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [1:0]  mem_we;
  logic [2:0]  mem_rsel;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        flush;
  logic        stall;

  logic        ram_en;
  logic [31:0] ram_addr;
  logic [1:0]  ram_we;
  logic [2:0]  ram_rsel;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport master (
    output if_req, if_addr, mem_req, mem_addr, mem_we, mem_rsel, mem_wdata,
    output flush, ram_rdata,
    input  if_ready, if_inst, mem_ready, mem_rdata, stall,
    input  ram_en, ram_addr, ram_we, ram_rsel, ram_wdata
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_addr, mem_we, mem_rsel, mem_wdata,
    input  flush, ram_rdata,
    output if_ready, if_inst, mem_ready, mem_rdata, stall,
    output ram_en, ram_addr, ram_we, ram_rsel, ram_wdata
  );

endinterface

// File: rtl/mem_port_arb.sv
// Arbitrates one single-port RAM between instruction fetch and data access;
// data wins in IDLE, each access holds the port for RAM_LAT cycles.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int RAM_LAT = RAM_LAT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  mem_port_arb_if.slave bus
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RAM_LAT);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(1);

  arb_state_t       state;
  logic [LAT_W-1:0] cnt;
  logic             flushed;
  logic             store_q;

  logic        ram_en_q;
  logic [31:0] ram_addr_q;
  logic [1:0]  ram_we_q;
  logic [2:0]  ram_rsel_q;
  logic [31:0] ram_wdata_q;
  logic        if_ready_q;
  logic [31:0] if_inst_q;
  logic        mem_ready_q;
  logic [31:0] mem_rdata_q;

  // A flush seen in any cycle of a fetch, sticky or on the final cycle, kills its ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      flushed     <= 1'b0;
      store_q     <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= WE_NONE;
      ram_rsel_q  <= '0;
      ram_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      if_inst_q   <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= WE_NONE;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mem_req) begin
            state       <= BUSY_MEM;
            cnt         <= LAT_INIT;
            ram_en_q    <= 1'b1;
            ram_addr_q  <= bus.mem_addr;
            ram_we_q    <= bus.mem_we;
            ram_rsel_q  <= bus.mem_rsel;
            ram_wdata_q <= bus.mem_wdata;
            store_q     <= (bus.mem_we != WE_NONE);
          end else if (bus.if_req && !bus.flush) begin
            state       <= BUSY_IF;
            cnt         <= LAT_INIT;
            ram_en_q    <= 1'b1;
            ram_addr_q  <= bus.if_addr;
            ram_rsel_q  <= '0;
            ram_wdata_q <= '0;
            flushed     <= 1'b0;
          end
        end
        BUSY_IF: begin
          if (cnt == LAT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            if (!(flushed || bus.flush)) begin
              if_ready_q <= 1'b1;
              if_inst_q  <= bus.ram_rdata;
            end
          end else begin
            cnt     <= cnt - 1'b1;
            flushed <= flushed | bus.flush;
          end
        end
        BUSY_MEM: begin
          if (cnt == LAT_LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_ready_q <= 1'b1;
            mem_rdata_q <= store_q ? 32'h0 : bus.ram_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_rsel  = ram_rsel_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.stall     = (bus.if_req & ~if_ready_q) | (bus.mem_req & ~mem_ready_q);

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: one instance at RAM_LAT=1, one at RAM_LAT=3,
// each with a RAM model that presents data only in the cycle it must be captured.
module tb_mem_port_arb;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  logic [31:0] ram_data1;
  logic [31:0] ram_data3;
  int          valid1;
  int          valid3;

  mem_port_arb_if b1 ();
  mem_port_arb_if b3 ();

  mem_port_arb #(.RAM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  mem_port_arb #(.RAM_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: strobe seen in cycle c makes data valid only in cycle c+LAT-1,
  // so it is registered at the edge RAM_LAT cycles after ram_en rose.
  always @(negedge clk) begin
    if (b1.ram_en) valid1 = cyc;
    if (b3.ram_en) valid3 = cyc + 2;
    b1.ram_rdata = (cyc == valid1) ? ram_data1 : 32'hBAD1BAD1;
    b3.ram_rdata = (cyc == valid3) ? ram_data3 : 32'hBAD3BAD3;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    b1.if_req = 1'b1;
    b1.if_addr = 32'h0000_0080;
    tick; tick;
    checks++; if (b1.ram_en !== 1'b0) begin failures++; $display("[TB] FAIL rst_ram_en got=%0h exp=0", b1.ram_en); end
    checks++; if (b1.ram_we !== 2'b00) begin failures++; $display("[TB] FAIL rst_ram_we got=%0h exp=0", b1.ram_we); end
    checks++; if (b1.if_ready !== 1'b0 || b1.mem_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready got=%0b%0b exp=00", b1.if_ready, b1.mem_ready); end
    checks++; if (b1.if_inst !== 32'h0 || b1.mem_rdata !== 32'h0) begin failures++; $display("[TB] FAIL rst_data got=%0h/%0h exp=0/0", b1.if_inst, b1.mem_rdata); end
    checks++; if (b3.ram_en !== 1'b0 || b3.ram_we !== 2'b00) begin failures++; $display("[TB] FAIL rst_ram3 got=%0b/%0h exp=0/0", b3.ram_en, b3.ram_we); end
    b1.if_req = 1'b0;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_fetch;
    b1.if_req = 1'b1;
    b1.if_addr = 32'h1C00_0000;
    ram_data1 = 32'h0280_0421;
    tick;
    checks++; if (b1.ram_en !== 1'b1) begin failures++; $display("[TB] FAIL fetch_en got=%0b exp=1", b1.ram_en); end
    checks++; if (b1.ram_addr !== 32'h1C00_0000) begin failures++; $display("[TB] FAIL fetch_addr got=%0h exp=1c000000", b1.ram_addr); end
    checks++; if (b1.ram_we !== 2'b00 || b1.ram_rsel !== 3'b000) begin failures++; $display("[TB] FAIL fetch_ctl got=%0h/%0h exp=0/0", b1.ram_we, b1.ram_rsel); end
    checks++; if (b1.if_ready !== 1'b0 || b1.stall !== 1'b1) begin failures++; $display("[TB] FAIL fetch_busy got=rdy%0b stall%0b exp=rdy0 stall1", b1.if_ready, b1.stall); end
    tick;
    checks++; if (b1.if_ready !== 1'b1) begin failures++; $display("[TB] FAIL fetch_ready got=%0b exp=1", b1.if_ready); end
    checks++; if (b1.if_inst !== 32'h0280_0421) begin failures++; $display("[TB] FAIL fetch_inst got=%0h exp=02800421", b1.if_inst); end
    checks++; if (b1.ram_en !== 1'b0 || b1.stall !== 1'b0) begin failures++; $display("[TB] FAIL fetch_done got=en%0b stall%0b exp=en0 stall0", b1.ram_en, b1.stall); end
    b1.if_req = 1'b0;
    tick;
    checks++; if (b1.if_ready !== 1'b0 || b1.ram_en !== 1'b0) begin failures++; $display("[TB] FAIL fetch_after got=rdy%0b en%0b exp=0 0", b1.if_ready, b1.ram_en); end
  endtask

  task automatic test_priority;
    b1.if_req = 1'b1;
    b1.if_addr = 32'h0000_0040;
    b1.mem_req = 1'b1;
    b1.mem_we = 2'b11;
    b1.mem_rsel = 3'b000;
    b1.mem_addr = 32'h0000_0100;
    b1.mem_wdata = 32'hDEAD_BEEF;
    ram_data1 = 32'h1111_2222;
    tick;
    checks++; if (b1.ram_en !== 1'b1 || b1.ram_we !== 2'b11) begin failures++; $display("[TB] FAIL prio_store got=en%0b we%0h exp=en1 we3", b1.ram_en, b1.ram_we); end
    checks++; if (b1.ram_addr !== 32'h100 || b1.ram_wdata !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL prio_store_bus got=%0h/%0h exp=100/deadbeef", b1.ram_addr, b1.ram_wdata); end
    tick;
    checks++; if (b1.mem_ready !== 1'b1 || b1.if_ready !== 1'b0) begin failures++; $display("[TB] FAIL prio_mem_first got=mem%0b if%0b exp=mem1 if0", b1.mem_ready, b1.if_ready); end
    checks++; if (b1.mem_rdata !== 32'h0 || b1.ram_we !== 2'b00) begin failures++; $display("[TB] FAIL prio_store_rdata got=%0h/%0h exp=0/0", b1.mem_rdata, b1.ram_we); end
    b1.mem_req = 1'b0;
    b1.mem_we = 2'b00;
    tick;
    checks++; if (b1.ram_en !== 1'b1 || b1.ram_addr !== 32'h40 || b1.ram_we !== 2'b00) begin failures++; $display("[TB] FAIL prio_fetch_grant got=en%0b addr%0h we%0h exp=en1 addr40 we0", b1.ram_en, b1.ram_addr, b1.ram_we); end
    tick;
    checks++; if (b1.if_ready !== 1'b1 || b1.mem_ready !== 1'b0 || b1.if_inst !== 32'h1111_2222) begin failures++; $display("[TB] FAIL prio_fetch_done got=if%0b mem%0b inst%0h exp=if1 mem0 inst11112222", b1.if_ready, b1.mem_ready, b1.if_inst); end
    b1.if_req = 1'b0;
    tick;
  endtask

  task automatic test_flush;
    b1.if_req = 1'b1;
    b1.if_addr = 32'h0000_0200;
    b1.flush = 1'b1;
    ram_data1 = 32'hAAAA_5555;
    tick;
    checks++; if (b1.ram_en !== 1'b0 || b1.stall !== 1'b1) begin failures++; $display("[TB] FAIL flush_idle got=en%0b stall%0b exp=en0 stall1", b1.ram_en, b1.stall); end
    b1.flush = 1'b0;
    tick;
    checks++; if (b1.ram_en !== 1'b1 || b1.ram_addr !== 32'h200) begin failures++; $display("[TB] FAIL flush_regrant got=en%0b addr%0h exp=en1 addr200", b1.ram_en, b1.ram_addr); end
    b1.flush = 1'b1;
    tick;
    checks++; if (b1.if_ready !== 1'b0) begin failures++; $display("[TB] FAIL flush_last got=%0b exp=0", b1.if_ready); end
    b1.flush = 1'b0;
    b1.if_addr = 32'h0000_0204;
    ram_data1 = 32'hCAFE_F00D;
    tick;
    checks++; if (b1.ram_en !== 1'b1 || b1.ram_addr !== 32'h204) begin failures++; $display("[TB] FAIL flush_next_grant got=en%0b addr%0h exp=en1 addr204", b1.ram_en, b1.ram_addr); end
    tick;
    checks++; if (b1.if_ready !== 1'b1 || b1.if_inst !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL flush_next_ready got=rdy%0b inst%0h exp=rdy1 instcafef00d", b1.if_ready, b1.if_inst); end
    b1.if_req = 1'b0;
    tick;
  endtask

  task automatic test_lat3_load;
    int en_seen;
    en_seen = 0;
    b3.mem_req = 1'b1;
    b3.mem_we = 2'b00;
    b3.mem_rsel = 3'b001;
    b3.mem_addr = 32'h0000_0300;
    ram_data3 = 32'h8765_4321;
    for (int k = 1; k <= 4; k++) begin
      tick;
      if (b3.ram_en === 1'b1) en_seen++;
      if (k == 1) begin
        checks++; if (b3.ram_rsel !== 3'b001 || b3.ram_we !== 2'b00 || b3.ram_addr !== 32'h300) begin failures++; $display("[TB] FAIL lat3_ctl got=rsel%0h we%0h addr%0h exp=rsel1 we0 addr300", b3.ram_rsel, b3.ram_we, b3.ram_addr); end
      end
      if (k < 4) begin
        checks++; if (b3.mem_ready !== 1'b0 || b3.stall !== 1'b1) begin failures++; $display("[TB] FAIL lat3_wait%0d got=rdy%0b stall%0b exp=rdy0 stall1", k, b3.mem_ready, b3.stall); end
      end
    end
    checks++; if (en_seen != 1) begin failures++; $display("[TB] FAIL lat3_en_count got=%0d exp=1", en_seen); end
    checks++; if (b3.mem_ready !== 1'b1 || b3.mem_rdata !== 32'h8765_4321 || b3.stall !== 1'b0) begin failures++; $display("[TB] FAIL lat3_ready got=rdy%0b data%0h stall%0b exp=rdy1 data87654321 stall0", b3.mem_ready, b3.mem_rdata, b3.stall); end
    b3.mem_req = 1'b0;
    tick;
    checks++; if (b3.mem_ready !== 1'b0) begin failures++; $display("[TB] FAIL lat3_pulse got=%0b exp=0", b3.mem_ready); end
  endtask

  task automatic test_lat3_flush_drop;
    b3.if_req = 1'b1;
    b3.if_addr = 32'h0000_0600;
    ram_data3 = 32'h2468_ACE0;
    tick;
    tick;
    b3.flush = 1'b1;
    tick;
    b3.flush = 1'b0;
    b3.if_req = 1'b0;
    tick;
    checks++; if (b3.if_ready !== 1'b0 || b3.ram_en !== 1'b0) begin failures++; $display("[TB] FAIL lat3_flush_mid got=rdy%0b en%0b exp=0 0", b3.if_ready, b3.ram_en); end
    b3.mem_req = 1'b1;
    b3.mem_we = 2'b00;
    b3.mem_rsel = 3'b010;
    b3.mem_addr = 32'h0000_0700;
    ram_data3 = 32'h1357_2468;
    tick;
    b3.mem_req = 1'b0;
    tick; tick; tick;
    checks++; if (b3.mem_ready !== 1'b1 || b3.mem_rdata !== 32'h1357_2468) begin failures++; $display("[TB] FAIL lat3_drop_req got=rdy%0b data%0h exp=rdy1 data13572468", b3.mem_ready, b3.mem_rdata); end
    tick;
  endtask

  task automatic test_reset_busy;
    b1.mem_req = 1'b1;
    b1.mem_we = 2'b00;
    b1.mem_rsel = 3'b100;
    b1.mem_addr = 32'h0000_0500;
    ram_data1 = 32'h5A5A_0F0F;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (b1.mem_ready !== 1'b0 || b1.ram_en !== 1'b0 || b1.ram_we !== 2'b00) begin failures++; $display("[TB] FAIL rstbusy_kill got=rdy%0b en%0b we%0h exp=0 0 0", b1.mem_ready, b1.ram_en, b1.ram_we); end
    checks++; if (b1.if_inst !== 32'h0 || b1.mem_rdata !== 32'h0) begin failures++; $display("[TB] FAIL rstbusy_data got=%0h/%0h exp=0/0", b1.if_inst, b1.mem_rdata); end
    tick;
    checks++; if (b1.ram_en !== 1'b1 || b1.ram_addr !== 32'h500 || b1.ram_rsel !== 3'b100) begin failures++; $display("[TB] FAIL rstbusy_regrant got=en%0b addr%0h rsel%0h exp=en1 addr500 rsel4", b1.ram_en, b1.ram_addr, b1.ram_rsel); end
    tick;
    checks++; if (b1.mem_ready !== 1'b1 || b1.mem_rdata !== 32'h5A5A_0F0F) begin failures++; $display("[TB] FAIL rstbusy_ready got=rdy%0b data%0h exp=rdy1 data5a5a0f0f", b1.mem_ready, b1.mem_rdata); end
    b1.mem_req = 1'b0;
    tick;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    valid1 = -10;
    valid3 = -10;
    ram_data1 = '0;
    ram_data3 = '0;
    rst = 1'b1;
    b1.if_req = 1'b0; b1.if_addr = '0; b1.mem_req = 1'b0; b1.mem_addr = '0;
    b1.mem_we = 2'b00; b1.mem_rsel = 3'b000; b1.mem_wdata = '0; b1.flush = 1'b0;
    b3.if_req = 1'b0; b3.if_addr = '0; b3.mem_req = 1'b0; b3.mem_addr = '0;
    b3.mem_we = 2'b00; b3.mem_rsel = 3'b000; b3.mem_wdata = '0; b3.flush = 1'b0;
    $display("[TB] starting mem_port_arb directed tests");
    test_reset();
    test_fetch();
    test_priority();
    test_flush();
    test_lat3_load();
    test_lat3_flush_drop();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
